// File: rtl/mux_arbitro_rr.sv
// mux_arbitro_rr: round-robin arbiter driving a registered 2-to-1 mux with bounded bursts
module mux_arbitro_rr #(
    parameter int WIDTH     = 2,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid0,
    input  logic [WIDTH-1:0] data_in0,
    output logic             ready0,
    input  logic             valid1,
    input  logic [WIDTH-1:0] data_in1,
    output logic             ready1,
    input  logic             ready_out,
    output logic             selector,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, SERV0, SERV1} state_t;

    localparam logic [3:0] MB = 4'(MAX_BURST);

    state_t     state;
    logic [3:0] cnt;
    logic       last;
    logic       gnt;
    logic       g;
    logic       can_accept;
    logic       xfer;

    // Some channel always wins while anything is valid; reset masks the handshake.
    assign gnt        = (valid0 || valid1) && !reset;
    assign can_accept = !valid_out || ready_out;
    assign xfer       = gnt && can_accept;
    assign selector   = gnt && g;
    assign ready0     = xfer && !g;
    assign ready1     = xfer && g;
    assign busy       = state != IDLE;

    // Winner: owner keeps the grant until its burst is spent while the other waits.
    always_comb begin
        g = (state == SERV0) ? !(valid0 && (cnt < MB || !valid1)) :
            (state == SERV1) ? (valid1 && (cnt < MB || !valid0)) :
            (valid0 && valid1) ? ~last : valid1;
    end

    // Ownership, burst count and the registered output stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            last      <= 1'b1;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else if (xfer) begin
            data_out  <= g ? data_in1 : data_in0;
            valid_out <= 1'b1;
            last      <= g;
            if (state == (g ? SERV1 : SERV0)) begin
                cnt <= (cnt >= MB) ? MB : cnt + 4'd1;
            end else begin
                state <= g ? SERV1 : SERV0;
                cnt   <= 4'd1;
            end
        end else begin
            if (ready_out) valid_out <= 1'b0;
            if (!valid0 && !valid1) begin
                state <= IDLE;
                cnt   <= 4'd0;
            end
        end
    end
endmodule

// File: tb/tb_mux_arbitro_rr.sv
// tb_mux_arbitro_rr: directed scenarios plus randomized run against a behavioural model
module tb_mux_arbitro_rr;
    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valid0 = 1'b0, valid1 = 1'b0, ready_out = 1'b0;
    logic [1:0] data_in0 = '0, data_in1 = '0;
    logic       ready0, ready1, selector, valid_out, busy;
    logic [1:0] data_out;

    int pass_cnt = 0;
    int total = 0;

    // behavioural model: owner (-1 = none), unsaturated run length, last winner
    int         m_owner, m_run, m_last;
    logic [1:0] m_dout;
    logic       m_vout;
    logic       e_gv, e_g;

    mux_arbitro_rr #(.WIDTH(2), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .valid0(valid0), .data_in0(data_in0), .ready0(ready0),
        .valid1(valid1), .data_in1(data_in1), .ready1(ready1),
        .ready_out(ready_out), .selector(selector),
        .data_out(data_out), .valid_out(valid_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        m_owner = -1; m_run = 0; m_last = 1; m_dout = 2'b00; m_vout = 1'b0;
        tick();
    endtask

    task automatic model_comb();
        logic v [2];
        v[0] = valid0; v[1] = valid1;
        e_gv = valid0 || valid1;
        e_g  = 1'b0;
        if (m_owner < 0) begin
            e_g = (valid0 && valid1) ? (m_last == 0) : valid1;
        end else if (v[m_owner] && (m_run < MB || !v[1-m_owner])) begin
            e_g = (m_owner == 1);
        end else begin
            e_g = (m_owner == 0);
        end
    endtask

    task automatic model_clock();
        model_comb();
        if (e_gv && (!m_vout || ready_out)) begin
            m_dout = e_g ? data_in1 : data_in0;
            m_vout = 1'b1;
            m_last = int'(e_g);
            if (m_owner == int'(e_g)) m_run++;
            else begin m_owner = int'(e_g); m_run = 1; end
        end else begin
            if (ready_out) m_vout = 1'b0;
            if (!valid0 && !valid1) begin m_owner = -1; m_run = 0; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; valid0 = 1'b1; valid1 = 1'b1; ready_out = 1'b1;
        #1;
        total++;
        if ({ready0, ready1, selector, data_out, valid_out, busy} !== 7'b0)
            $display("FAIL reset_state got r0=%b r1=%b sel=%b d=%b v=%b busy=%b want all 0",
                     ready0, ready1, selector, data_out, valid_out, busy);
        else pass_cnt++;
        reset = 1'b0; valid1 = 1'b0; data_in0 = 2'b11;
        tick(); tick();
        total++;
        if ({valid_out, data_out} !== 3'b111) $display("FAIL reset_pre got v=%b d=%b want v=1 d=11", valid_out, data_out);
        else pass_cnt++;
        reset = 1'b1;
        #1;
        total++;
        if ({ready0, ready1, data_out, valid_out, busy} !== 6'b0)
            $display("FAIL reset_mid got r0=%b r1=%b d=%b v=%b busy=%b want all 0", ready0, ready1, data_out, valid_out, busy);
        else pass_cnt++;
        reset = 1'b0; valid0 = 1'b1; valid1 = 1'b1;
        #1;
        total++;
        if ({selector, ready0, ready1} !== 3'b010) $display("FAIL reset_first_tie got sel=%b r0=%b r1=%b want 0 1 0", selector, ready0, ready1);
        else pass_cnt++;
        valid0 = 1'b0; valid1 = 1'b0;
        apply_reset();
    endtask

    task automatic test_single();
        valid0 = 1'b1; valid1 = 1'b0; data_in0 = 2'b10; ready_out = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if ({ready0, ready1, selector} !== 3'b100) $display("FAIL single_hs[%0d] got r0=%b r1=%b sel=%b want 1 0 0", i, ready0, ready1, selector);
            else pass_cnt++;
            if (i > 0) begin
                total++;
                if ({valid_out, data_out, busy} !== 4'b1101) $display("FAIL single_out[%0d] got v=%b d=%b busy=%b want 1 10 1", i, valid_out, data_out, busy);
                else pass_cnt++;
            end
            tick();
        end
        valid0 = 1'b0;
        apply_reset();
    endtask

    task automatic test_burst();
        logic es;
        valid0 = 1'b1; valid1 = 1'b1; data_in0 = 2'b01; data_in1 = 2'b11; ready_out = 1'b1;
        for (int k = 0; k < 16; k++) begin
            #1;
            es = ((k / MB) % 2) == 1;
            total++;
            if ({selector, ready0, ready1} !== {es, !es, es}) $display("FAIL burst_grant[%0d] got sel=%b r0=%b r1=%b want sel=%b", k, selector, ready0, ready1, es);
            else pass_cnt++;
            if (k > 0) begin
                total++;
                if (data_out !== ((((k - 1) / MB) % 2) == 1 ? 2'b11 : 2'b01)) $display("FAIL burst_data[%0d] got %b", k, data_out);
                else pass_cnt++;
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        valid0 = 1'b0; valid1 = 1'b1; data_in1 = 2'b01; ready_out = 1'b1;
        #1;
        total++;
        if (ready1 !== 1'b1) $display("FAIL bp_pre got r1=%b want 1", ready1);
        else pass_cnt++;
        tick();
        data_in1 = 2'b10; ready_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({ready1, ready0, data_out, valid_out, busy} !== 6'b000111) $display("FAIL bp_stall[%0d] got r1=%b r0=%b d=%b v=%b busy=%b want 0 0 01 1 1", i, ready1, ready0, data_out, valid_out, busy);
            else pass_cnt++;
            tick();
        end
        ready_out = 1'b1;
        #1;
        total++;
        if (ready1 !== 1'b1) $display("FAIL bp_resume got r1=%b want 1", ready1);
        else pass_cnt++;
        tick();
        data_in1 = 2'b11;
        #1;
        total++;
        if ({valid_out, data_out} !== 3'b110) $display("FAIL bp_data1 got v=%b d=%b want 1 10", valid_out, data_out);
        else pass_cnt++;
        tick();
        #1;
        total++;
        if ({valid_out, data_out} !== 3'b111) $display("FAIL bp_data2 got v=%b d=%b want 1 11", valid_out, data_out);
        else pass_cnt++;
        valid1 = 1'b0;
        apply_reset();
    endtask

    task automatic test_handoff();
        valid0 = 1'b1; valid1 = 1'b0; data_in0 = 2'b01; ready_out = 1'b1;
        tick(); tick();
        valid0 = 1'b0; valid1 = 1'b1; data_in1 = 2'b10;
        #1;
        total++;
        if ({selector, ready1, ready0, busy} !== 4'b1101) $display("FAIL handoff got sel=%b r1=%b r0=%b busy=%b want 1 1 0 1", selector, ready1, ready0, busy);
        else pass_cnt++;
        tick();
        valid0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if (selector !== (k < MB - 1)) $display("FAIL handoff_cnt[%0d] got sel=%b want %b", k, selector, k < MB - 1);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_drain();
        valid0 = 1'b0; valid1 = 1'b0; ready_out = 1'b1;
        #1;
        total++;
        if ({valid_out, ready0, ready1} !== 3'b100) $display("FAIL drain_last got v=%b r0=%b r1=%b want 1 0 0", valid_out, ready0, ready1);
        else pass_cnt++;
        tick();
        #1;
        total++;
        if ({valid_out, busy} !== 2'b00) $display("FAIL drain_idle got v=%b busy=%b want 0 0", valid_out, busy);
        else pass_cnt++;
        valid0 = 1'b1; valid1 = 1'b1;
        #1;
        total++;
        if ({selector, ready1} !== 2'b11) $display("FAIL drain_tie got sel=%b r1=%b want 1 1", selector, ready1);
        else pass_cnt++;
        valid0 = 1'b0; valid1 = 1'b0;
        apply_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            valid0    = ($urandom_range(0, 3) != 0);
            valid1    = ($urandom_range(0, 3) != 0);
            data_in0  = 2'($urandom_range(0, 3));
            data_in1  = 2'($urandom_range(0, 3));
            ready_out = ($urandom_range(0, 3) != 0);
            #1;
            model_comb();
            total++;
            if ({ready0, ready1, selector} !== {e_gv && !e_g && (!m_vout || ready_out), e_gv && e_g && (!m_vout || ready_out), e_gv && e_g})
                $display("FAIL rand_hs[%0d] got r0=%b r1=%b sel=%b want gv=%b g=%b", i, ready0, ready1, selector, e_gv, e_g);
            else pass_cnt++;
            total++;
            if ({data_out, valid_out, busy} !== {m_dout, m_vout, m_owner >= 0})
                $display("FAIL rand_out[%0d] got d=%b v=%b busy=%b want d=%b v=%b busy=%b", i, data_out, valid_out, busy, m_dout, m_vout, m_owner >= 0);
            else pass_cnt++;
            @(posedge clk);
            model_clock();
            #1;
        end
    endtask

    initial begin
        m_owner = -1; m_run = 0; m_last = 1; m_dout = 2'b00; m_vout = 1'b0;
        e_gv = 1'b0; e_g = 1'b0;
        tick();
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_handoff();
        test_drain();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
